// File: rtl/emitter_hex_formatter.sv
// emitter_hex_formatter: buffers binary words in a small FIFO and streams each
// one out as uppercase ASCII hex (MS nibble first), optionally followed by CR LF,
// over a valid/ready byte interface feeding the UART emitter.
// Ports:
//   i_clk, i_rst        clock (rising edge), async active-high reset
//   i_word, i_word_valid, o_word_ready   word input handshake (ready = !full)
//   o_data, o_valid, i_ready             ASCII byte output handshake
//   o_busy              FIFO non-empty or a word is being formatted
module emitter_hex_formatter #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned NEWLINE    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WORD_W-1:0] i_word,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic [7:0]        o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NIB_N = WORD_W / 4;
  localparam int unsigned NIB_W = (NIB_N > 1) ? $clog2(NIB_N) : 1;
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(NIB_N - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DIGIT, ST_CR, ST_LF} state_t;

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, empty, push, pop, shift, accept, eow;

  state_t            state, state_next;
  logic [WORD_W-1:0] shreg, shreg_next;
  logic [NIB_W-1:0]  nib_cnt, nib_next;
  logic [7:0]        data_next;
  logic              valid_next, out_en;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    // 'A' - 10 = 0x37
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign full         = (count == CNT_FULL);
  assign empty        = (count == '0);
  assign push         = i_word_valid & ~full;
  assign accept       = o_valid & i_ready;
  assign o_word_ready = ~full;
  assign o_busy       = ~empty | (state != ST_IDLE);

  // FIFO storage; validity is tracked by the pointers/count only
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_word;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      nib_cnt <= '0;
      o_data  <= 8'h00;
      o_valid <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      nib_cnt <= nib_next;
      if (out_en) begin
        o_data  <= data_next;
        o_valid <= valid_next;
      end
    end
  end

  // Next-state logic; end of word chains straight into the next FIFO entry
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    shift      = 1'b0;
    eow        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = ST_DIGIT;
        end
      end
      ST_DIGIT: begin
        if (accept) begin
          if (nib_cnt != '0)     shift      = 1'b1;
          else if (NEWLINE != 0) state_next = ST_CR;
          else                   eow        = 1'b1;
        end
      end
      ST_CR:   if (accept) state_next = ST_LF;
      ST_LF:   if (accept) eow = 1'b1;
      default: state_next = ST_IDLE;
    endcase
    if (eow) begin
      if (!empty) begin
        pop        = 1'b1;
        state_next = ST_DIGIT;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  // Output / datapath next values; byte regs move only on accept or a load
  always_comb begin
    shreg_next = shreg;
    nib_next   = nib_cnt;
    if (pop) begin
      shreg_next = mem[rd_ptr];
      nib_next   = NIB_LAST;
    end else if (shift) begin
      shreg_next = shreg << 4;
      nib_next   = nib_cnt - NIB_W'(1);
    end
    out_en     = accept | pop;
    valid_next = (state_next != ST_IDLE);
    case (state_next)
      ST_DIGIT: data_next = hex_char(shreg_next[WORD_W-1 -: 4]);
      ST_CR:    data_next = 8'h0D;
      ST_LF:    data_next = 8'h0A;
      default:  data_next = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_emitter_hex_formatter.sv
module tb_emitter_hex_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word;
  logic        word_valid;
  logic        word_ready;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        busy;

  logic [7:0]  p_word;
  logic        p_word_valid;
  logic        p_word_ready;
  logic [7:0]  p_data;
  logic        p_valid;
  logic        p_ready;
  logic        p_busy;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  emitter_hex_formatter dut (
    .i_clk(clk), .i_rst(rst), .i_word(word), .i_word_valid(word_valid),
    .o_word_ready(word_ready), .o_data(data), .o_valid(valid),
    .i_ready(ready), .o_busy(busy)
  );

  emitter_hex_formatter #(.WORD_W(8), .FIFO_DEPTH(4), .NEWLINE(0)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_word(p_word), .i_word_valid(p_word_valid),
    .o_word_ready(p_word_ready), .o_data(p_data), .o_valid(p_valid),
    .i_ready(p_ready), .o_busy(p_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference formatting of a 32-bit word with CR LF
  task automatic add_word(input logic [31:0] w);
    logic [3:0] n;
    for (int i = 7; i >= 0; i--) begin
      n = w[4*i +: 4];
      exp_q.push_back((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // Drain exp_q.size() bytes; every visible byte (held or accepted) must match
  task automatic collect(input bit rnd, output int cycles);
    int idx;
    idx    = 0;
    cycles = 0;
    while (idx < exp_q.size() && cycles < 2000) begin
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid) begin
        chk($sformatf("byte%0d", idx), 32'(data), 32'(exp_q[idx]));
        if (ready) idx++;
      end
      step();
      cycles++;
    end
    if (idx < exp_q.size()) chk("collect_timeout", 32'(idx), 32'(exp_q.size()));
    ready = 1'b1;
  endtask

  initial begin
    int cyc;
    int accepted;
    logic [31:0] fw [5];

    rst = 1'b1; word = '0; word_valid = 1'b0; ready = 1'b1;
    p_word = '0; p_word_valid = 1'b0; p_ready = 1'b1;
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wready", 32'(word_ready), 32'd1);
    step();
    rst = 1'b0;
    step();

    // Single word, ready held high
    word = 32'hDEADBEEF; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    chk("lat_valid0", 32'(valid), 32'd0);
    chk("lat_busy", 32'(busy), 32'd1);
    step();
    chk("lat_valid1", 32'(valid), 32'd1);
    exp_q = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    collect(1'b0, cyc);
    chk("single_cycles", 32'(cyc), 32'd10);
    chk("single_busy_end", 32'(busy), 32'd0);
    chk("single_valid_end", 32'(valid), 32'd0);

    // Same word under random backpressure
    word = 32'hDEADBEEF; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    step();
    collect(1'b1, cyc);
    step();
    chk("bp_busy_end", 32'(busy), 32'd0);

    // FIFO full with ready low
    ready = 1'b0;
    accepted = 0;
    for (int k = 0; k < 8; k++) begin
      word = 32'h01234567 + 32'(k) * 32'h11111111;
      word_valid = 1'b1;
      if (word_ready) begin
        if (accepted < 5) fw[accepted] = word;
        accepted++;
      end
      step();
    end
    word_valid = 1'b0;
    chk("full_accepted", 32'(accepted), 32'd5);
    chk("full_wready", 32'(word_ready), 32'd0);
    chk("full_first_byte", 32'(data), 32'h30);
    exp_q.delete();
    for (int k = 0; k < 5; k++) add_word(fw[k]);
    collect(1'b0, cyc);
    chk("full_cycles", 32'(cyc), 32'd50);
    chk("full_wready_end", 32'(word_ready), 32'd1);
    chk("full_busy_end", 32'(busy), 32'd0);

    // Back-to-back words, no bubble
    word = 32'h00000000; word_valid = 1'b1;
    step();
    word = 32'h12345678;
    chk("b2b_valid0", 32'(valid), 32'd0);
    step();
    word_valid = 1'b0;
    exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A,
              8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};
    collect(1'b0, cyc);
    chk("b2b_cycles", 32'(cyc), 32'd20);
    chk("b2b_busy_end", 32'(busy), 32'd0);

    // Reset mid-word after 3 accepted bytes
    word = 32'hDEADBEEF; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    step();
    step(); step(); step();
    chk("mid_data", 32'(data), 32'h44);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_wready", 32'(word_ready), 32'd1);
    #1 rst = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("post_rst_idle", 32'(valid), 32'd0);
      step();
    end
    word = 32'h00000001; word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    step();
    exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
    collect(1'b0, cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd10);

    // 8-bit words, no newline
    p_word = 8'h0A; p_word_valid = 1'b1;
    step();
    p_word = 8'hF9;
    chk("p_valid0", 32'(p_valid), 32'd0);
    step();
    p_word_valid = 1'b0;
    chk("p_b0", 32'(p_data), 32'h30);
    chk("p_v0", 32'(p_valid), 32'd1);
    step();
    chk("p_b1", 32'(p_data), 32'h41);
    step();
    chk("p_b2", 32'(p_data), 32'h46);
    chk("p_v2", 32'(p_valid), 32'd1);
    step();
    chk("p_b3", 32'(p_data), 32'h39);
    step();
    chk("p_valid_end", 32'(p_valid), 32'd0);
    chk("p_busy_end", 32'(p_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/emitter_hex_formatter.md
# emitter_hex_formatter

Converts binary words into ASCII hexadecimal text for the byte-serial UART emitter. It accepts whole words over a valid/ready handshake and buffers them in a small FIFO. Each word is emitted most-significant nibble first as uppercase hex characters, optionally followed by CR LF. It sits directly upstream of the UART emitter and drives that emitter's `i_data`/`i_valid`, taking its `o_ready` as `i_ready`.

## Interface
- `WORD_W`, default 32: input word width; must be a multiple of 4 and at least 4.
- `FIFO_DEPTH`, default 4: word FIFO depth; must be a power of two and at least 2.
- `NEWLINE`, default 1: 1 appends 0x0D 0x0A after each word; 0 emits digits only.

Ports:
- `i_clk` input 1: sole clock, rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_word` input `WORD_W`: word to format.
- `i_word_valid` input 1: `i_word` is valid.
- `o_word_ready` output 1: FIFO can accept a word; equals !full.
- `o_data` output 8: ASCII byte to the emitter.
- `o_valid` output 1: `o_data` is valid.
- `i_ready` input 1: the emitter accepts `o_data`.
- `o_busy` output 1: FIFO non-empty or a word is being formatted.

## Operation
- Word accept: `i_word_valid & o_word_ready` at a rising edge pushes `i_word` into the FIFO.
- FIFO:
  - Circular buffer with rd/wr pointers of $clog2(FIFO_DEPTH) bits that wrap naturally.
  - Occupancy count is $clog2(FIFO_DEPTH)+1 bits.
  - Push and pop in the same cycle leave the count unchanged.
  - A push while full cannot occur because ready is low. A pop while empty never occurs.
- FSM states:
  - IDLE: `o_valid`=0. If the FIFO is non-empty, pop the head into a `WORD_W` shift register, set the nibble counter to `WORD_W`/4-1, and go to DIGIT.
  - DIGIT: `o_valid`=1 and `o_data`=hex(top nibble). On byte accept:
    - If the nibble counter is not 0: shift left by 4 and decrement the counter.
    - Else if `NEWLINE`=1: go to CR.
    - Else: go to the end-of-word step.
  - CR: `o_data`=0x0D. On byte accept, go to LF.
  - LF: `o_data`=0x0A. On byte accept, go to the end-of-word step.
  - End-of-word step: if the FIFO is non-empty, pop the next word and go directly to DIGIT with no bubble. Otherwise go to IDLE with `o_valid`=0.
- Hex mapping: nibble 0–9 maps to 0x30+n; nibble 10–15 maps to 0x41+(n-10), uppercase.
- Byte accept means `o_valid & i_ready` at a rising edge.
- `o_data` and `o_valid` are registered.
  - They change only on a byte accept or on the IDLE→DIGIT transition.
  - While `o_valid=1 & i_ready=0`, `o_data` is held stable.
- `o_busy` = (count≠0) | (state≠IDLE).

## Timing
- Reset values: `o_valid`=0, `o_data`=0x00, state IDLE, FIFO empty, `o_busy`=0, `o_word_ready`=1.
- Reset mid-operation:
  - Asserting `i_rst` clears FIFO contents and any in-flight word immediately, without waiting for a clock edge.
  - After release, no byte is produced until a new word is pushed.
- Latency: a word accepted at edge N into an empty, idle block gives `o_valid`=1 with its first digit after edge N+1.
- Throughput: with `i_ready` held at 1, one byte per cycle with no gaps between words while the FIFO holds data.
- Capacity:
  - With `i_ready` held at 0, exactly `FIFO_DEPTH`+1 words are accepted: one sits in the shift register, `FIFO_DEPTH` in the FIFO.
  - `o_word_ready` falls in the cycle after the push that fills the FIFO.
- `o_word_ready` depends only on registered count, never combinationally on `i_ready`.
- Bytes per word: `WORD_W`/4 + 2·`NEWLINE`.

## Test plan
- Single word, `i_ready`=1: push 0xDEADBEEF → bytes 44 45 41 44 42 45 45 46 0D 0A on 10 consecutive cycles; first byte one cycle after accept; `o_busy` falls after LF.
- Backpressure: same word with `i_ready` randomly toggled → identical byte sequence; `o_data` never changes while `o_valid=1 & i_ready=0`.
- FIFO full: `i_ready`=0, offer 8 words with `FIFO_DEPTH`=4 → exactly 5 accepted, `o_word_ready`=0. Then raise `i_ready` → 5 words emitted in order (50 bytes), and `o_word_ready` rises after the first pop.
- Back-to-back: push 0x00000000 and 0x12345678 with `i_ready`=1 → 20 contiguous bytes, 30×8 0D 0A 31 32 33 34 35 36 37 38 0D 0A, no bubble.
- Parameters: `WORD_W`=8, `NEWLINE`=0, push 0x0A then 0xF9 → 30 41 46 39.
- Reset mid-word: after 3 bytes of 0xDEADBEEF, pulse `i_rst` between edges → `o_valid`=0 immediately, `o_busy`=0, `o_word_ready`=1. No bytes appear until a new push; a new push of 0x00000001 yields 30×7 31 0D 0A.
